seq_alu_core: RTL and testbench

Parametrised, handshaked successor to the team's multi-stage ALU. It holds an operand register A and a result register G, and executes register-register and immediate operations under a START/DONE handshake. It adds a multi-cycle shift-and-add multiply, status flags and illegal-op reporting. It sits on the datapath bus between the register file and the control FSM; RES drives the shared bus only while Gout is high.

---
 rtl/seq_alu_pkg.sv | 50 +++++
 rtl/seq_alu_mul.sv | 48 ++++
 rtl/seq_alu_core.sv | 192 +++++++++++++++++++
 tb/tb_seq_alu_core.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared function codes, operand modes, FSM states and flag layout
// for the sequential ALU core and its multiplier.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        FN_ADD = 4'b0010,
        FN_SUB = 4'b0011,
        FN_NEG = 4'b0100,
        FN_FLP = 4'b0101,
        FN_AND = 4'b0110,
        FN_OR  = 4'b0111,
        FN_XOR = 4'b1000,
        FN_LSL = 4'b1001,
        FN_LSR = 4'b1010,
        FN_ASR = 4'b1011,
        FN_MUL = 4'b1100
    } fn_t;

    typedef enum logic [1:0] {
        MODE_RR   = 2'b00,
        MODE_ILL  = 2'b01,
        MODE_ADDI = 2'b10,
        MODE_SUBI = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MULT,
        S_DONE
    } state_t;

    // Bit order matches the FLAGS port: {Z, NF, C, V}.
    typedef struct packed {
        logic z;
        logic nf;
        logic c;
        logic v;
    } flags_t;

    // True for every function code the core can execute.
    function automatic logic fn_is_legal(input logic [3:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_NEG, FN_FLP, FN_AND, FN_OR,
            FN_XOR, FN_LSL, FN_LSR, FN_ASR, FN_MUL: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: iterative shift-and-add multiplier keeping the low N bits.
// The final partial sum is presented combinationally while o_done is high, so
// the owner captures the product on the same edge that ends the operation.
module seq_alu_mul #(
    parameter int N = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_product,
    output logic         o_done
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_mcand;
    logic [N-1:0]  r_mplier;
    logic [N-1:0]  w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_product  = w_acc_next;
    assign o_done     = (r_cnt == CW'(1));

    // Load operands on start, then add-and-shift once per edge until the count expires.
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_cnt    <= CW'(N);
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
        end else if (r_cnt != '0) begin
            r_cnt    <= r_cnt - CW'(1);
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

endmodule

// File: rtl/seq_alu_core.sv
// seq_alu_core: handshaked ALU with operand register A and result register G.
// Single-cycle ops go IDLE->EXEC->DONE; MUL goes IDLE->MULT->DONE via seq_alu_mul.
module seq_alu_core
    import seq_alu_pkg::*;
#(
    parameter int N    = 16,
    parameter int IMMW = 6,
    parameter int SHW  = $clog2(N)
) (
    input  logic         CLKb,
    input  logic         RSTb,
    input  logic [N-1:0] DIN,
    input  logic         Ain,
    input  logic [N-1:0] B,
    input  logic [3:0]   FN,
    input  logic [1:0]   MODE,
    input  logic         START,
    input  logic         Gout,
    output logic [N-1:0] RES,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERR,
    output logic [3:0]   FLAGS
);

    state_t          r_state;
    state_t          w_next_state;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_g;
    logic [N-1:0]    r_b;
    logic [3:0]      r_fn;
    logic [1:0]      r_mode;
    logic [IMMW-1:0] r_imm;
    flags_t          r_flags;
    logic            r_err;

    logic            w_start_acc;
    logic            w_mul_req;
    logic            w_mul_start;
    logic            w_mul_done;
    logic            w_legal;
    logic [3:0]      w_eff_fn;
    logic [N-1:0]    w_a_eff;
    logic [N-1:0]    w_opnd;
    logic [N-1:0]    w_alu_res;
    logic [N-1:0]    w_mul_prod;
    logic [N:0]      w_sum;
    logic [N:0]      w_diff;
    logic [SHW-1:0]  w_shamt;
    logic signed [N-1:0] w_a_signed;
    flags_t          w_alu_flags;

    assign w_start_acc = START && (r_state == S_IDLE);
    assign w_mul_req   = (MODE == MODE_RR) && (FN == FN_MUL);
    assign w_mul_start = w_start_acc && w_mul_req;
    // A load and START on the same edge: the operation sees the new A.
    assign w_a_eff     = Ain ? DIN : r_a;

    assign RES   = Gout ? r_g : '0;
    assign ERR   = r_err;
    assign FLAGS = r_flags;

    seq_alu_mul #(.N(N)) u_mul (
        .i_clk     (CLKb),
        .i_rst_n   (RSTb),
        .i_start   (w_mul_start),
        .i_a       (w_a_eff),
        .i_b       (B),
        .o_product (w_mul_prod),
        .o_done    (w_mul_done)
    );

    // State register.
    always_ff @(negedge CLKb or negedge RSTb) begin
        // NOTE: clocked state uses <= so every register samples pre-edge values.
        if (!RSTb) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        w_next_state = r_state;
        BUSY         = 1'b0;
        DONE         = 1'b0;
        case (r_state)
            S_IDLE: if (START) w_next_state = w_mul_req ? S_MULT : S_EXEC;
            S_EXEC: begin
                BUSY         = 1'b1;
                w_next_state = S_DONE;
            end
            S_MULT: begin
                BUSY = 1'b1;
                if (w_mul_done) w_next_state = S_DONE;
            end
            S_DONE: begin
                DONE         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // A accepts DIN only while idle.
    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb)                         r_a <= '0;
        else if (r_state == S_IDLE && Ain) r_a <= DIN;
    end

    // Capture B, FN, MODE and the immediate at the accepted START.
    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            r_b    <= '0;
            r_fn   <= '0;
            r_mode <= '0;
            r_imm  <= '0;
        end else if (w_start_acc) begin
            r_b    <= B;
            r_fn   <= FN;
            r_mode <= MODE;
            r_imm  <= DIN[IMMW-1:0];
        end
    end

    // Immediate modes reuse the ADD/SUB datapath.
    always_comb begin
        case (r_mode)
            MODE_ADDI: w_eff_fn = FN_ADD;
            MODE_SUBI: w_eff_fn = FN_SUB;
            default:   w_eff_fn = r_fn;
        endcase
    end

    assign w_legal    = (r_mode != MODE_ILL) && fn_is_legal(w_eff_fn);
    assign w_opnd     = (r_mode == MODE_RR) ? r_b : {{(N-IMMW){1'b0}}, r_imm};
    assign w_sum      = {1'b0, r_a} + {1'b0, w_opnd};
    // Bit N of the extended difference is the unsigned borrow (A < operand).
    assign w_diff     = {1'b0, r_a} - {1'b0, w_opnd};
    assign w_shamt    = r_b[SHW-1:0];
    assign w_a_signed = r_a;

    // Single-cycle ALU result and flags.
    always_comb begin
        w_alu_res   = '0;
        w_alu_flags = '0;
        case (w_eff_fn)
            FN_ADD: begin
                w_alu_res     = w_sum[N-1:0];
                w_alu_flags.c = w_sum[N];
                w_alu_flags.v = (r_a[N-1] == w_opnd[N-1]) && (w_sum[N-1] != r_a[N-1]);
            end
            FN_SUB: begin
                w_alu_res     = w_diff[N-1:0];
                w_alu_flags.c = w_diff[N];
                w_alu_flags.v = (r_a[N-1] != w_opnd[N-1]) && (w_diff[N-1] != r_a[N-1]);
            end
            FN_NEG:  w_alu_res = ~r_a + N'(1);
            FN_FLP:  w_alu_res = ~r_a;
            FN_AND:  w_alu_res = r_a & r_b;
            FN_OR:   w_alu_res = r_a | r_b;
            FN_XOR:  w_alu_res = r_a ^ r_b;
            FN_LSL:  w_alu_res = r_a << w_shamt;
            FN_LSR:  w_alu_res = r_a >> w_shamt;
            FN_ASR:  w_alu_res = w_a_signed >>> w_shamt;
            default: w_alu_res = '0;
        endcase
        w_alu_flags.z  = (w_alu_res == '0);
        w_alu_flags.nf = w_alu_res[N-1];
    end

    // G, FLAGS and the sticky error flag; illegal ops leave G and FLAGS alone.
    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            r_g     <= '0;
            r_flags <= '0;
            r_err   <= 1'b0;
        end else if (w_start_acc) begin
            r_err <= 1'b0;
        end else if (r_state == S_EXEC) begin
            if (w_legal) begin
                r_g     <= w_alu_res;
                r_flags <= w_alu_flags;
            end else begin
                r_err <= 1'b1;
            end
        end else if (r_state == S_MULT && w_mul_done) begin
            r_g     <= w_mul_prod;
            r_flags <= '{z: (w_mul_prod == '0), nf: w_mul_prod[N-1], c: 1'b0, v: 1'b0};
        end
    end

endmodule

// File: tb/tb_seq_alu_core.sv
// tb_seq_alu_core: table-driven and randomized checks of seq_alu_core (N=16)
// against a plain-arithmetic reference model.
module tb_seq_alu_core;

    localparam logic [3:0] F_ADD = 4'b0010, F_SUB = 4'b0011, F_NEG = 4'b0100,
                           F_FLP = 4'b0101, F_AND = 4'b0110, F_OR  = 4'b0111,
                           F_XOR = 4'b1000, F_LSL = 4'b1001, F_LSR = 4'b1010,
                           F_ASR = 4'b1011, F_MUL = 4'b1100, F_BAD = 4'b1111;

    logic        CLKb, RSTb, Ain, START, Gout;
    logic [15:0] DIN, B, RES;
    logic [3:0]  FN, FLAGS;
    logic [1:0]  MODE;
    logic        BUSY, DONE, ERR;

    int n_chk = 0;
    int n_err = 0;

    seq_alu_core #(.N(16), .IMMW(6)) dut (
        .CLKb(CLKb), .RSTb(RSTb), .DIN(DIN), .Ain(Ain), .B(B), .FN(FN),
        .MODE(MODE), .START(START), .Gout(Gout), .RES(RES), .BUSY(BUSY),
        .DONE(DONE), .ERR(ERR), .FLAGS(FLAGS)
    );

    initial begin
        CLKb = 1'b1;
        forever #5 CLKb = ~CLKb;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [15:0] g;
        logic [3:0]  fl;
        logic        err;
    } res_t;

    typedef struct {
        int          ld;    // 0: no load, 1: load A first, 2: load A on the START edge
        logic [15:0] a, b, din;
        logic [3:0]  fn;
        logic [1:0]  mode;
        logic [15:0] eg;
        logic [3:0]  ef;
        logic        ee;
    } vec_t;

    vec_t vt[$];
    logic [15:0] m_g;
    logic [3:0]  m_fl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance past the next active (falling) edge and settle.
    task automatic tick();
        @(negedge CLKb);
        #1;
    endtask

    // Reference model: spec rules with plain integer arithmetic.
    function automatic res_t model(input logic [15:0] a, b, din, input logic [3:0] fn,
                                   input logic [1:0] mode, input logic [15:0] g_prev,
                                   input logic [3:0] f_prev);
        res_t   r;
        longint ua, uo, sa, so, x;
        logic [3:0] code;
        logic   c, v;
        int     sh;
        ua = a;
        sa = longint'($signed(a));
        if (mode == 2'b00) begin
            uo   = b;
            so   = longint'($signed(b));
            code = fn;
        end else begin
            uo   = din % 64;
            so   = uo;
            code = (mode == 2'b10) ? F_ADD : (mode == 2'b11) ? F_SUB : 4'b0000;
        end
        sh = b % 16;
        c  = 1'b0;
        v  = 1'b0;
        x  = 0;
        case (code)
            F_ADD: begin x = ua + uo; c = (x > 65535); v = (sa + so > 32767) || (sa + so < -32768); end
            F_SUB: begin x = ua - uo; c = (ua < uo);   v = (sa - so > 32767) || (sa - so < -32768); end
            F_NEG: x = -ua;
            F_FLP: x = ~ua;
            F_AND: x = ua & uo;
            F_OR:  x = ua | uo;
            F_XOR: x = ua ^ uo;
            F_LSL: x = ua << sh;
            F_LSR: x = ua >> sh;
            F_ASR: x = sa >>> sh;
            F_MUL: x = ua * uo;
            default: begin
                r.g = g_prev; r.fl = f_prev; r.err = 1'b1;
                return r;
            end
        endcase
        r.g   = x[15:0];
        r.fl  = {r.g == 16'h0000, r.g[15], c, v};
        r.err = 1'b0;
        return r;
    endfunction

    // One complete START/DONE transaction with latency, result and handshake checks.
    task automatic do_op(input string tag, input int ld, input logic [15:0] a, b, din,
                         input logic [3:0] fn, input logic [1:0] mode,
                         input logic [15:0] eg, input logic [3:0] ef, input logic ee);
        int lat;
        int exp_lat;
        exp_lat = (mode == 2'b00 && fn == F_MUL) ? 16 : 1;
        if (ld == 1) begin
            DIN = a; Ain = 1'b1;
            tick();
            Ain = 1'b0;
        end
        DIN = din; B = b; FN = fn; MODE = mode; START = 1'b1; Ain = (ld == 2);
        tick();
        START = 1'b0; Ain = 1'b0;
        B = 16'($urandom); FN = 4'($urandom); MODE = 2'($urandom); DIN = 16'($urandom);
        check({tag, " busy after start"}, BUSY, 1);
        check({tag, " err cleared at start"}, ERR, 0);
        lat = 0;
        while (DONE !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " done latency"}, lat, exp_lat);
        check({tag, " res with gout=0"}, RES, 0);
        Gout = 1'b1;
        #1;
        check({tag, " G"}, RES, eg);
        check({tag, " flags"}, FLAGS, ef);
        check({tag, " err"}, ERR, ee);
        check({tag, " busy at done"}, BUSY, 0);
        Gout = 1'b0;
        tick();
        check({tag, " done one cycle"}, DONE, 0);
    endtask

    initial begin
        int lat;
        int busy_cnt;
        logic seen_done;

        RSTb = 1'b1; Ain = 1'b0; START = 1'b0; Gout = 1'b0;
        DIN = '0; B = '0; FN = '0; MODE = '0;
        #2 RSTb = 1'b0;
        #1;
        check("reset busy", BUSY, 0);
        check("reset done", DONE, 0);
        check("reset err", ERR, 0);
        check("reset flags", FLAGS, 0);
        Gout = 1'b1;
        #1;
        check("reset G", RES, 0);
        Gout = 1'b0;
        tick();
        tick();
        RSTb = 1'b1;

        // A resets to 0, so FLP without a load yields all ones.
        do_op("reset A flp", 0, 16'h0000, 16'h0000, 16'h0000, F_FLP, 2'b00, 16'hFFFF, 4'b0100, 1'b0);

        //                ld  a         b         din       fn     mode   exp_g     {Z,NF,C,V} err
        vt.push_back('{1, 16'h7FFF, 16'h0001, 16'h0000, F_ADD, 2'b00, 16'h8000, 4'b0101, 1'b0});
        vt.push_back('{1, 16'h0003, 16'h0000, 16'h0005, F_ADD, 2'b11, 16'hFFFE, 4'b0110, 1'b0});
        vt.push_back('{1, 16'h8000, 16'h0014, 16'h0000, F_ASR, 2'b00, 16'hF800, 4'b0100, 1'b0});
        vt.push_back('{1, 16'h0123, 16'h0010, 16'h0000, F_MUL, 2'b00, 16'h1230, 4'b0000, 1'b0});
        vt.push_back('{1, 16'h1234, 16'h0001, 16'h0000, F_BAD, 2'b00, 16'h1230, 4'b0000, 1'b1});
        vt.push_back('{1, 16'hFFFF, 16'h0001, 16'h0000, F_ADD, 2'b00, 16'h0000, 4'b1010, 1'b0});
        vt.push_back('{1, 16'h0005, 16'h0001, 16'h0000, F_ADD, 2'b01, 16'h0000, 4'b1010, 1'b1});
        vt.push_back('{1, 16'h8000, 16'h0001, 16'h0000, F_SUB, 2'b00, 16'h7FFF, 4'b0001, 1'b0});
        vt.push_back('{1, 16'h0005, 16'h0005, 16'h0000, F_SUB, 2'b00, 16'h0000, 4'b1000, 1'b0});
        vt.push_back('{1, 16'h0000, 16'h0001, 16'h0000, F_SUB, 2'b00, 16'hFFFF, 4'b0110, 1'b0});
        vt.push_back('{1, 16'h8000, 16'h8000, 16'h0000, F_ADD, 2'b00, 16'h0000, 4'b1011, 1'b0});
        vt.push_back('{1, 16'h0001, 16'h1234, 16'h0000, F_NEG, 2'b00, 16'hFFFF, 4'b0100, 1'b0});
        vt.push_back('{1, 16'h0000, 16'h1234, 16'h0000, F_NEG, 2'b00, 16'h0000, 4'b1000, 1'b0});
        vt.push_back('{1, 16'hF0F0, 16'h0000, 16'h0000, F_FLP, 2'b00, 16'h0F0F, 4'b0000, 1'b0});
        vt.push_back('{1, 16'hFF00, 16'h0FF0, 16'h0000, F_AND, 2'b00, 16'h0F00, 4'b0000, 1'b0});
        vt.push_back('{1, 16'hFF00, 16'h0FF0, 16'h0000, F_OR,  2'b00, 16'hFFF0, 4'b0100, 1'b0});
        vt.push_back('{1, 16'hFF00, 16'h0FF0, 16'h0000, F_XOR, 2'b00, 16'hF0F0, 4'b0100, 1'b0});
        vt.push_back('{1, 16'h0001, 16'hFFFF, 16'h0000, F_LSL, 2'b00, 16'h8000, 4'b0100, 1'b0});
        vt.push_back('{1, 16'h8000, 16'h000F, 16'h0000, F_LSR, 2'b00, 16'h0001, 4'b0000, 1'b0});
        vt.push_back('{1, 16'h7000, 16'h0003, 16'h0000, F_ASR, 2'b00, 16'h0E00, 4'b0000, 1'b0});
        vt.push_back('{1, 16'hFFFF, 16'hFFFF, 16'h0000, F_MUL, 2'b00, 16'h0001, 4'b0000, 1'b0});
        vt.push_back('{1, 16'hFFF0, 16'h0000, 16'hABFF, F_ADD, 2'b10, 16'h002F, 4'b0010, 1'b0});
        vt.push_back('{1, 16'h0040, 16'h0000, 16'h0001, F_BAD, 2'b11, 16'h003F, 4'b0000, 1'b0});
        vt.push_back('{2, 16'h0041, 16'h0000, 16'h0041, F_AND, 2'b10, 16'h0042, 4'b0000, 1'b0});
        vt.push_back('{1, 16'h0002, 16'h0000, 16'h0003, F_MUL, 2'b10, 16'h0005, 4'b0000, 1'b0});

        foreach (vt[i])
            do_op($sformatf("vec%0d", i), vt[i].ld, vt[i].a, vt[i].b, vt[i].din,
                  vt[i].fn, vt[i].mode, vt[i].eg, vt[i].ef, vt[i].ee);

        // MUL with START and Ain asserted while busy and during DONE: both ignored.
        DIN = 16'h0123; Ain = 1'b1;
        tick();
        Ain = 1'b0;
        B = 16'h0010; FN = F_MUL; MODE = 2'b00; START = 1'b1;
        tick();
        FN = F_ADD; B = 16'hFFFF; DIN = 16'hFFFF; Ain = 1'b1;
        lat = 0;
        busy_cnt = 0;
        while (DONE !== 1'b1 && lat < 40) begin
            if (BUSY === 1'b1) busy_cnt++;
            if (lat == 10) begin START = 1'b0; Ain = 1'b0; end
            tick();
            lat++;
        end
        check("mul busy cycles", busy_cnt, 16);
        check("mul done latency", lat, 16);
        Gout = 1'b1;
        #1;
        check("mul G", RES, 16'h1230);
        Gout = 1'b0;
        START = 1'b1; FN = F_FLP; Ain = 1'b1; DIN = 16'h0000;
        tick();
        START = 1'b0; Ain = 1'b0;
        check("start in done ignored busy", BUSY, 0);
        check("start in done ignored done", DONE, 0);
        tick();
        check("idle after done busy", BUSY, 0);
        check("idle after done pulse", DONE, 0);
        do_op("A kept through busy", 0, 16'h0000, 16'h0000, 16'h0000, F_ADD, 2'b00,
              16'h0123, 4'b0000, 1'b0);

        // Reset in the middle of a MUL aborts it with no DONE pulse.
        DIN = 16'h0123; Ain = 1'b1;
        tick();
        Ain = 1'b0;
        B = 16'h0010; FN = F_MUL; MODE = 2'b00; START = 1'b1;
        tick();
        START = 1'b0;
        repeat (5) tick();
        check("mid-mul busy", BUSY, 1);
        RSTb = 1'b0;
        #1;
        check("abort busy", BUSY, 0);
        check("abort done", DONE, 0);
        Gout = 1'b1;
        #1;
        check("abort G", RES, 0);
        Gout = 1'b0;
        seen_done = 1'b0;
        repeat (2) begin tick(); seen_done |= DONE; end
        RSTb = 1'b1;
        repeat (20) begin tick(); seen_done |= DONE; end
        check("abort no done pulse", seen_done, 0);
        check("abort idle", BUSY, 0);
        Gout = 1'b1;
        #1;
        check("read after abort", RES, 16'h0000);
        check("flags after abort", FLAGS, 0);
        Gout = 1'b0;

        // Randomized transactions against the reference model.
        m_g  = 16'h0000;
        m_fl = 4'b0000;
        for (int i = 0; i < 150; i++) begin
            logic [15:0] a, b, din;
            logic [3:0]  fn;
            logic [1:0]  mode;
            int          ld, k;
            res_t        r;
            ld  = ($urandom_range(0, 3) == 0) ? 2 : 1;
            din = 16'($urandom);
            a   = (ld == 2) ? din : 16'($urandom);
            b   = 16'($urandom);
            fn  = 4'($urandom_range(0, 15));
            k   = $urandom_range(0, 9);
            mode = (k < 6) ? 2'b00 : (k == 6) ? 2'b01 : (k < 9) ? 2'b10 : 2'b11;
            r = model(a, b, din, fn, mode, m_g, m_fl);
            do_op($sformatf("rand%0d fn=%h mode=%b a=%h b=%h din=%h", i, fn, mode, a, b, din),
                  ld, a, b, din, fn, mode, r.g, r.fl, r.err);
            m_g  = r.g;
            m_fl = r.fl;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
